// File: rtl/beta_alu_issue.sv
// Instruction-side issue stage for the Beta combinational ALU: decodes one ALU-class
// instruction per handshake, drives the ALU operands, waits ALU_WAIT cycles, writes back.
module beta_alu_issue #(
    parameter int ALU_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [4:0]  rc_q, rc_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] rf_q [31];
    logic [31:0] rf_d [31];

    logic [5:0]  dec_op;
    logic [4:0]  dec_rc;
    logic [4:0]  dec_ra;
    logic [4:0]  dec_rb;
    logic [31:0] dec_lit;
    logic        dec_legal;
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic        accept;

    assign instr_ready = (state_q == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    // R31 is not stored; every read of it returns zero.
    always_comb begin
        dec_op    = instr[31:26];
        dec_rc    = instr[25:21];
        dec_ra    = instr[20:16];
        dec_rb    = instr[15:11];
        dec_lit   = {{16{instr[15]}}, instr[15:0]};
        dec_legal = dec_op[5] && (dec_op[3:0] != 4'd7) && (dec_op[3:0] != 4'd15);
        ra_val    = (dec_ra == 5'd31) ? 32'd0 : rf_q[dec_ra];
        rb_val    = (dec_rb == 5'd31) ? 32'd0 : rf_q[dec_rb];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rc_d      = rc_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        rf_d      = rf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_legal) begin
                        alu_a_d  = ra_val;
                        alu_b_d  = dec_op[4] ? dec_lit : rb_val;
                        alu_op_d = dec_op[3:0];
                        rc_d     = dec_rc;
                        count_d  = WAIT_LOAD;
                        state_d  = S_EXEC;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    if (rc_q != 5'd31) begin
                        rf_d[rc_q] = alu_out;
                    end
                    wb_addr_d = rc_q;
                    wb_data_d = alu_out;
                    state_d   = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            rc_q      <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            for (int i = 0; i < 31; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rc_q      <= rc_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            for (int i = 0; i < 31; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign wb_valid = (state_q == S_WB);
    assign illegal  = (state_q == S_ERR);
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign dbg_data = (dbg_addr == 5'd31) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_beta_alu_issue.sv
// Directed bench for beta_alu_issue: one DUT at ALU_WAIT=2, one at ALU_WAIT=1,
// each fed by a behavioural Beta ALU model.
module tb_beta_alu_issue;

    logic        clk;
    logic        reset_n;

    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        wb_valid, illegal;
    logic [4:0]  wb_addr, dbg_addr;
    logic [31:0] wb_data, dbg_data;

    logic        instr_valid2, instr_ready2;
    logic [31:0] instr2;
    logic [31:0] alu_a2, alu_b2, alu_out2;
    logic [3:0]  alu_op2;
    logic        wb_valid2, illegal2;
    logic [4:0]  wb_addr2, dbg_addr2;
    logic [31:0] wb_data2, dbg_data2;

    int tests_run;
    int tests_failed;

    beta_alu_issue #(.ALU_WAIT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    beta_alu_issue #(.ALU_WAIT(1)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_out(alu_out2),
        .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .illegal(illegal2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b == 32'd0) ? 32'd0 : 32'($signed(a) / $signed(b));
            4'd4:  r = {31'd0, a == b};
            4'd5:  r = {31'd0, $signed(a) < $signed(b)};
            4'd6:  r = {31'd0, $signed(a) <= $signed(b)};
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a ^ b);
            4'd12: r = a << b[4:0];
            4'd13: r = a >> b[4:0];
            4'd14: r = 32'($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_out  = alu_model(alu_a, alu_b, alu_op);
    assign alu_out2 = alu_model(alu_a2, alu_b2, alu_op2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offers a word on the first DUT and returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [31:0] word);
        bit ok;
        ok = 0;
        instr = word;
        instr_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        instr_valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL accept_timeout: word %h not accepted in 10 cycles", word);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        dbg_addr = 5'd1;
        #1;
        tests_run++;
        if ({instr_ready, wb_valid, illegal} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 100", {instr_ready, wb_valid, illegal});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_op, wb_addr, wb_data} !== 105'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: a=%h b=%h op=%h wa=%h wd=%h expected all 0",
                     alu_a, alu_b, alu_op, wb_addr, wb_data);
        end
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_r1: got %h expected 0", dbg_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addc();
        applyStimulus(32'hC03F0005);
        tests_run++;
        if (instr_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL addc_ready_drop: got %b expected 0", instr_ready);
        end
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {32'd0, 32'd5, 4'd0}) begin
            tests_failed++;
            $display("[TB] FAIL addc_operands: a=%h b=%h op=%h expected 0/5/0", alu_a, alu_b, alu_op);
        end
        @(posedge clk); #1;
        tests_run++;
        if (wb_valid !== 1'b0 || alu_b !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL addc_hold: wb_valid=%b b=%h expected 0/5", wb_valid, alu_b);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd1, 32'd5}) begin
            tests_failed++;
            $display("[TB] FAIL addc_wb: v=%b addr=%0d data=%h expected 1/1/5", wb_valid, wb_addr, wb_data);
        end
        dbg_addr = 5'd1;
        #1;
        tests_run++;
        if (dbg_data !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL addc_dbg_r1: got %h expected 5", dbg_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({wb_valid, instr_ready, wb_data} !== {1'b0, 1'b1, 32'd5}) begin
            tests_failed++;
            $display("[TB] FAIL addc_after_wb: v=%b rdy=%b data=%h expected 0/1/5", wb_valid, instr_ready, wb_data);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(32'hC441FFFF);
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {32'd5, 32'hFFFFFFFF, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL subc_operands: a=%h b=%h op=%h expected 5/ffffffff/1", alu_a, alu_b, alu_op);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd2, 32'd6}) begin
            tests_failed++;
            $display("[TB] FAIL subc_wb: v=%b addr=%0d data=%h expected 1/2/6", wb_valid, wb_addr, wb_data);
        end
        tests_run++;
        if (instr_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL subc_ready_in_wb: got %b expected 0", instr_ready);
        end
        applyStimulus(32'h88621000);
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {32'd6, 32'd6, 4'd2}) begin
            tests_failed++;
            $display("[TB] FAIL mul_operands: a=%h b=%h op=%h expected 6/6/2", alu_a, alu_b, alu_op);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd3, 32'd36}) begin
            tests_failed++;
            $display("[TB] FAIL mul_wb: v=%b addr=%0d data=%h expected 1/3/24", wb_valid, wb_addr, wb_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        words[0] = 32'h9C200000;
        words[1] = 32'h40400000;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(words[k]);
            tests_run++;
            if ({illegal, wb_valid, instr_ready} !== 3'b100) begin
                tests_failed++;
                $display("[TB] FAIL illegal_pulse_%0d: ill/wbv/rdy=%b expected 100", k, {illegal, wb_valid, instr_ready});
            end
            tests_run++;
            if ({alu_a, alu_op} !== {32'd6, 4'd2}) begin
                tests_failed++;
                $display("[TB] FAIL illegal_alu_hold_%0d: a=%h op=%h expected 6/2", k, alu_a, alu_op);
            end
            @(posedge clk); #1;
            tests_run++;
            if ({illegal, wb_valid, instr_ready} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL illegal_recover_%0d: ill/wbv/rdy=%b expected 001", k, {illegal, wb_valid, instr_ready});
            end
        end
        dbg_addr = 5'd1; #1;
        tests_run++;
        if (dbg_data !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL illegal_r1: got %h expected 5", dbg_data);
        end
        dbg_addr = 5'd2; #1;
        tests_run++;
        if (dbg_data !== 32'd6) begin
            tests_failed++;
            $display("[TB] FAIL illegal_r2: got %h expected 6", dbg_data);
        end
        dbg_addr = 5'd3; #1;
        tests_run++;
        if (dbg_data !== 32'd36) begin
            tests_failed++;
            $display("[TB] FAIL mul_r3: got %h expected 24", dbg_data);
        end
        tests_run++;
        if (wb_data !== 32'd36) begin
            tests_failed++;
            $display("[TB] FAIL illegal_wb_hold: got %h expected 24", wb_data);
        end
    endtask

    task automatic test_r31();
        applyStimulus(32'hC3FF0007);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd31, 32'd7}) begin
            tests_failed++;
            $display("[TB] FAIL r31_wb: v=%b addr=%0d data=%h expected 1/31/7", wb_valid, wb_addr, wb_data);
        end
        dbg_addr = 5'd31; #1;
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL r31_dbg: got %h expected 0", dbg_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        applyStimulus(32'hC09F0009);
        tests_run++;
        if (alu_b !== 32'd9) begin
            tests_failed++;
            $display("[TB] FAIL abort_operand: b=%h expected 9", alu_b);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_op, wb_addr, wb_data} !== 105'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_outputs: a=%h b=%h op=%h wa=%h wd=%h expected all 0",
                     alu_a, alu_b, alu_op, wb_addr, wb_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({wb_valid, illegal, instr_ready} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL abort_in_reset_%0d: wbv/ill/rdy=%b expected 001", i, {wb_valid, illegal, instr_ready});
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({wb_valid, instr_ready} !== 2'b01) begin
                tests_failed++;
                $display("[TB] FAIL abort_after_release_%0d: wbv/rdy=%b expected 01", i, {wb_valid, instr_ready});
            end
        end
        dbg_addr = 5'd4; #1;
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_r4: got %h expected 0", dbg_data);
        end
        dbg_addr = 5'd1; #1;
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_r1_cleared: got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] seen_data [3];
        int          seen_at   [3];
        int          n;
        logic [31:0] expect_data [3];
        expect_data[0] = 32'd2;
        expect_data[1] = 32'd4;
        expect_data[2] = 32'd8;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            seen_data[k] = '0;
            seen_at[k]   = 0;
        end
        @(negedge clk);
        instr2 = 32'hC0BF0001;
        instr_valid2 = 1'b1;
        @(posedge clk); #1;
        instr_valid2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dbg_addr2 = 5'd5; #1;
        tests_run++;
        if (dbg_data2 !== 32'd1 || instr_ready2 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stream_setup_r5: r5=%h rdy=%b expected 1/1", dbg_data2, instr_ready2);
        end
        instr2 = 32'hF0A50001;
        instr_valid2 = 1'b1;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(posedge clk); #1;
            if (wb_valid2) begin
                if (n < 3) begin
                    seen_data[n] = wb_data2;
                    seen_at[n]   = cyc;
                end
                n++;
            end
        end
        instr_valid2 = 1'b0;
        tests_run++;
        if (n < 3) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d writebacks expected at least 3", n);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (seen_data[k] !== expect_data[k]) begin
                tests_failed++;
                $display("[TB] FAIL stream_data_%0d: got %h expected %h", k, seen_data[k], expect_data[k]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            tests_run++;
            if (seen_at[k] - seen_at[k-1] != 3) begin
                tests_failed++;
                $display("[TB] FAIL stream_interval_%0d: got %0d cycles expected 3", k, seen_at[k] - seen_at[k-1]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        instr_valid  = 1'b0;
        instr        = '0;
        dbg_addr     = '0;
        instr_valid2 = 1'b0;
        instr2       = '0;
        dbg_addr2    = '0;
        reset_n      = 1'b0;

        test_reset();
        test_addc();
        test_back_to_back();
        test_illegal();
        test_r31();
        test_reset_abort();
        test_streaming();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/beta_alu_issue.md
Name: beta_alu_issue

Overview:
- Instruction-side driver for the Beta 32-bit combinational ALU.
- Accepts one Beta ALU-class instruction per handshake and decodes it.
- Reads operands from an internal 32x32 register file and drives the ALU's a/b/op inputs.
- Holds the operands stable for a programmable settle time, then captures the ALU result and writes it back to the register file.

Parameters:
- ALU_WAIT, 2, cycles operands are held before alu_out is sampled (legal 1..15; sized for the multiply/divide combinational paths).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word offered
- instr_ready  out  1  block can accept an instruction
- instr  in  32  Beta instruction: op[31:26] rc[25:21] ra[20:16] rb[15:11] lit[15:0]
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU function select
- alu_out  in  32  ALU result
- wb_valid  out  1  one-cycle pulse, writeback occurred
- wb_addr  out  5  destination register of the writeback
- wb_data  out  32  value written
- illegal  out  1  one-cycle pulse, rejected opcode
- dbg_addr  in  5  debug register-file read address
- dbg_data  out  32  combinational read of reg[dbg_addr]; R31 reads 0

Behaviour:
- Reset (async, active-low):
  - state=IDLE, all 31 registers=0, counter=0.
  - alu_a/alu_b/alu_op/wb_addr/wb_data=0; wb_valid=illegal=0.
  - Reset asserted mid-operation aborts it with no writeback.
- States: IDLE, EXEC, WB, ERR.
- instr_ready=1 only in IDLE. Acceptance = instr_valid & instr_ready at a rising edge (cycle T).
- Decode:
  - Legal iff op[5:4] is 2'b10 (register form) or 2'b11 (constant form) and op[3:0] is not 7 and not 15.
  - alu_op = op[3:0]: 0 add, 1 sub, 2 mul, 3 div, 4 cmpeq, 5 cmplt, 6 cmple, 8 and, 9 or, 10 xor, 11 xnor, 12 shl, 13 shr, 14 sra.
- Operands:
  - alu_a = reg[ra].
  - alu_b = reg[rb] in register form; lit[15:0] sign-extended to 32 bits in constant form.
  - R31 always reads 0.
- IDLE, legal accept at edge T:
  - Register alu_a/alu_b/alu_op (visible from T+1); load counter=ALU_WAIT-1; go to EXEC.
- IDLE, illegal accept:
  - ALU outputs unchanged; go to ERR. illegal=1 during cycle T+1 only.
  - ERR -> IDLE unconditionally. No register or wb change.
- EXEC:
  - alu_a/alu_b/alu_op held constant.
  - counter!=0: decrement, stay in EXEC.
  - counter==0: on that edge write alu_out to reg[rc] (suppressed if rc==31), load wb_addr=rc and wb_data=alu_out, go to WB.
- WB:
  - wb_valid=1 for exactly this cycle, T+ALU_WAIT+1. wb_valid also pulses when rc==31.
  - WB -> IDLE.
- Latency: acceptance to wb_valid = ALU_WAIT+1 cycles. Issue interval = ALU_WAIT+2 cycles.
- Hazards: the writeback lands before the next acceptance, so back-to-back dependent instructions see the updated value. No forwarding logic is needed.
- instr_valid is ignored outside IDLE. instr is sampled only at acceptance.
- wb_addr/wb_data hold their last values after WB. alu_* outputs hold after EXEC.
- dbg port is independent of state. A write and a dbg read of the same register show the new value from the cycle after the write edge.

Test Plan:
- Reset, then offer ADDC R1,R31,5 (0xC03F0005) with ALU_WAIT=2 -> instr_ready drops at T+1; alu_a=0, alu_b=5, alu_op=0 over T+1..T+2; wb_valid at T+3 with wb_addr=1, wb_data=5; dbg R1=5.
- After R1=5, SUBC R2,R1,-1 (lit 0xFFFF), then back-to-back MUL R3,R2,R2 -> alu_b=0xFFFFFFFF for the SUBC; R2=6; the MUL uses updated R2, giving R3=36.
- Offer opcode 0x27, then 0x10 -> each gives illegal pulse exactly one cycle, no wb_valid, regs unchanged, instr_ready back high two cycles after acceptance.
- ADDC R31,R31,7 -> wb_valid pulses with wb_addr=31, wb_data=7; dbg R31 still reads 0.
- Assert reset_n low during EXEC of ADDC R4,R31,9 -> all outputs 0 immediately, no wb_valid, R4=0, state IDLE after release.
- Hold instr_valid high continuously with SHLC R5,R5,1 after R5=1, ALU_WAIT=1 -> accepts every 3 cycles; successive wb_data 2, 4, 8.
